// File: rtl/mem_stage.sv
// Memory stage: drives the data bus for loads/stores and produces writeback.
// Define MEM_ACK_TIMEOUT_EN to turn unanswered bus requests into bus errors.
module mem_stage #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic        misaligned,
  output logic        bus_err
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t      state;
  logic        ld_load;
  logic        ld_rw;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_lane;

  logic        is_mem;
  logic        acc_bad;
  logic [1:0]  lane;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;
  logic [31:0] lane_data;
  logic [31:0] load_data;

`ifdef MEM_ACK_TIMEOUT_EN
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
`endif

  assign is_mem    = ex_mem_read | ex_mem_write;
  assign lane      = ex_alu_result[1:0];
  assign mem_stall = (state == S_WAIT);

  always_comb begin
    acc_bad   = 1'b0;
    acc_be    = 4'b0000;
    acc_wdata = '0;
    unique case (ex_funct3[1:0])
      2'b00: begin
        acc_be    = 4'b0001 << lane;
        acc_wdata = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        acc_bad   = lane[0];
        acc_be    = lane[1] ? 4'b1100 : 4'b0011;
        acc_wdata = {2{ex_store_data[15:0]}};
      end
      2'b10: begin
        acc_bad   = |lane;
        acc_be    = 4'b1111;
        acc_wdata = ex_store_data;
      end
      default: acc_bad = 1'b1;
    endcase
    // 110 would be an RV64 LWU; not legal here
    if (ex_funct3 == 3'b110)
      acc_bad = 1'b1;
  end

  assign lane_data = dmem_rdata >> {ld_lane, 3'b000};

  always_comb begin
    load_data = dmem_rdata;
    unique case (ld_f3)
      3'b000:  load_data = {{24{lane_data[7]}}, lane_data[7:0]};
      3'b001:  load_data = {{16{lane_data[15]}}, lane_data[15:0]};
      3'b100:  load_data = {24'b0, lane_data[7:0]};
      3'b101:  load_data = {16'b0, lane_data[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      ld_load      <= 1'b0;
      ld_rw        <= 1'b0;
      ld_f3        <= 3'b0;
      ld_lane      <= 2'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= 4'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'b0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
      misaligned   <= 1'b0;
      bus_err      <= 1'b0;
`ifdef MEM_ACK_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      wb_valid   <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (ex_valid) begin
            wb_rd <= ex_rd;
            if (!is_mem) begin
              wb_valid     <= 1'b1;
              wb_data      <= ex_alu_result;
              wb_reg_write <= ex_reg_write;
            end else if (acc_bad) begin
              wb_valid     <= 1'b1;
              misaligned   <= 1'b1;
              wb_data      <= '0;
              wb_reg_write <= 1'b0;
            end else begin
              state      <= S_WAIT;
              dmem_req   <= 1'b1;
              // read+write together behaves as a load
              dmem_we    <= ~ex_mem_read;
              dmem_addr  <= {ex_alu_result[31:2], 2'b00};
              dmem_wdata <= acc_wdata;
              dmem_be    <= acc_be;
              ld_load    <= ex_mem_read;
              ld_rw      <= ex_reg_write;
              ld_f3      <= ex_funct3;
              ld_lane    <= lane;
`ifdef MEM_ACK_TIMEOUT_EN
              wait_cnt   <= '0;
`endif
            end
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            state        <= S_IDLE;
            dmem_req     <= 1'b0;
            wb_valid     <= 1'b1;
            wb_reg_write <= ld_load & ld_rw;
            wb_data      <= ld_load ? load_data : '0;
          end
`ifdef MEM_ACK_TIMEOUT_EN
          else if (wait_cnt == CW'(ACK_TIMEOUT - 1)) begin
            state        <= S_IDLE;
            dmem_req     <= 1'b0;
            bus_err      <= 1'b1;
            wb_valid     <= 1'b1;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: per-cycle compare against a transaction model
// plus literal pins on the documented example vectors.
module tb_mem_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        misaligned;
  logic        bus_err;

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data),
    .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3),
    .mem_stall(mem_stall),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be),
    .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid),
    .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write),
    .wb_data(wb_data),
    .misaligned(misaligned),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        e_stall, e_req, e_we, e_wbv, e_rw;
  logic        e_chkd, e_mis, e_berr;
  logic [31:0] e_addr, e_wdata, e_data;
  logic [3:0]  e_be;
  logic [4:0]  e_rd;

  int          n_req = 0, n_mis = 0, n_berr = 0;
  int          n_wbv = 0, n_stall = 0;
  logic [31:0] l_wbdata, l_addr, l_wdata;
  logic [3:0]  l_be;
  logic        l_we, l_rw;
  logic [4:0]  l_rd;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_exp();
    e_stall = 0; e_req = 0; e_we = 0;
    e_wbv = 0; e_rw = 0; e_chkd = 0;
    e_mis = 0; e_berr = 0;
    e_addr = 0; e_wdata = 0; e_data = 0;
    e_be = 0; e_rd = 0;
  endtask

  function automatic int f_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit f_ok(input logic [2:0] f3,
                              input logic [31:0] a);
    if (f3[1:0] == 2'b11 || f3 == 3'b110) return 1'b0;
    return (a % f_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] f_be(input logic [2:0] f3,
                                      input logic [1:0] ln);
    int m;
    m = ((1 << f_size(f3)) - 1) << ln;
    return 4'(m);
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] f3,
                                          input logic [31:0] d);
    case (f_size(f3))
      1: return {24'b0, d[7:0]} * 32'h0101_0101;
      2: return {16'b0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3,
                                         input logic [1:0] ln,
                                         input logic [31:0] rd);
    longint s, v, m;
    int bits;
    bits = 8 * f_size(f3);
    if (bits == 32) return rd;
    s = longint'(rd) >> (8 * ln);
    m = longint'(1) << bits;
    v = s % m;
    if (!f3[2] && v >= m / 2) v = v - m;
    return 32'(v);
  endfunction

  task automatic do_op(input logic [31:0] alu,
                       input logic [31:0] sd,
                       input logic [4:0]  rd,
                       input logic        rw,
                       input logic        mr,
                       input logic        mw,
                       input logic [2:0]  f3,
                       input int          lat,
                       input logic [31:0] rdata,
                       input bit          follow);
    logic mem;
    bit   ok;
    int   n;
    mem = mr | mw;
    ok  = f_ok(f3, alu);
    n   = lat;
    ex_valid = 1; ex_alu_result = alu;
    ex_store_data = sd; ex_rd = rd;
    ex_reg_write = rw; ex_mem_read = mr;
    ex_mem_write = mw; ex_funct3 = f3;
    tick();
    ex_valid = 0;
    if (!mem) begin
      e_wbv = 1; e_rd = rd; e_rw = rw;
      e_data = alu; e_chkd = 1;
    end else if (!ok) begin
      e_wbv = 1; e_mis = 1; e_rd = rd;
      e_rw = 0; e_chkd = 0;
    end else begin
      e_stall = 1; e_req = 1; e_we = mw && !mr;
      e_addr = alu & ~32'd3;
      e_be = f_be(f3, alu[1:0]);
      e_wdata = f_wdata(f3, sd);
      if (follow) begin
        ex_valid = 1; ex_alu_result = 32'h00C0_FFEE;
        ex_rd = 7; ex_reg_write = 1;
        ex_mem_read = 0; ex_mem_write = 0;
        ex_funct3 = 0;
      end
`ifndef MEM_ACK_TIMEOUT_EN
      if (n == 0) n = TO + 5;
`endif
      if (n == 0) begin
        repeat (TO) tick();
        e_stall = 0; e_req = 0; e_berr = 1;
        e_wbv = 1; e_rd = rd; e_rw = 0; e_chkd = 0;
      end else begin
        repeat (n - 1) tick();
        dmem_ack = 1; dmem_rdata = rdata;
        tick();
        dmem_ack = 0; dmem_rdata = 0;
        e_stall = 0; e_req = 0;
        e_wbv = 1; e_rd = rd;
        e_rw = mr && rw; e_chkd = mr;
        e_data = f_load(f3, alu[1:0], rdata);
      end
      if (follow) begin
        tick();
        ex_valid = 0; e_berr = 0;
        e_wbv = 1; e_rd = 7; e_rw = 1;
        e_data = 32'h00C0_FFEE; e_chkd = 1;
      end
    end
    tick();
    clr_exp();
  endtask

  int r0, w0, m0, s0, b0;

  initial begin
    ex_valid = 0; ex_alu_result = 0;
    ex_store_data = 0; ex_rd = 0;
    ex_reg_write = 0; ex_mem_read = 0;
    ex_mem_write = 0; ex_funct3 = 0;
    dmem_ack = 0; dmem_rdata = 0;
    clr_exp();

    fork
      forever begin
        @(negedge clk);
        chk("mem_stall", 32'(mem_stall), 32'(e_stall));
        chk("dmem_req", 32'(dmem_req), 32'(e_req));
        chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
        chk("misaligned", 32'(misaligned), 32'(e_mis));
        chk("bus_err", 32'(bus_err), 32'(e_berr));
        if (e_req) begin
          chk("dmem_addr", dmem_addr, e_addr);
          chk("dmem_we", 32'(dmem_we), 32'(e_we));
          chk("dmem_be", 32'(dmem_be), 32'(e_be));
          if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
        end
        if (e_wbv) begin
          chk("wb_rd", 32'(wb_rd), 32'(e_rd));
          chk("wb_reg_write", 32'(wb_reg_write), 32'(e_rw));
          if (e_chkd) chk("wb_data", wb_data, e_data);
        end
        if (dmem_req) begin
          n_req++; l_addr = dmem_addr; l_wdata = dmem_wdata;
          l_be = dmem_be; l_we = dmem_we;
        end
        if (mem_stall) n_stall++;
        if (misaligned) n_mis++;
        if (bus_err) n_berr++;
        if (wb_valid) begin
          n_wbv++; l_wbdata = wb_data;
          l_rd = wb_rd; l_rw = wb_reg_write;
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_rd", 32'(wb_rd), 32'h0);
    chk("rst_dmem_addr", dmem_addr, 32'h0);
    chk("rst_dmem_be", 32'(dmem_be), 32'h0);
    @(posedge clk); #1;
    rst = 0;

    r0 = n_req; w0 = n_wbv;
    do_op(32'd15, 0, 5'd5, 1, 0, 0, 3'b000, 1, 0, 0);
    chk("add_data", l_wbdata, 32'd15);
    chk("add_rd", 32'(l_rd), 32'd5);
    chk("add_no_req", 32'(n_req - r0), 32'd0);
    chk("add_one_wb", 32'(n_wbv - w0), 32'd1);

    s0 = n_stall;
    do_op(32'h103, 0, 5'd9, 1, 1, 0, 3'b000, 3,
          32'h80FF_FF7F, 0);
    chk("lb_addr", l_addr, 32'h100);
    chk("lb_stall", 32'(n_stall - s0), 32'd3);
    chk("lb_data", l_wbdata, 32'hFFFF_FF80);
    do_op(32'h103, 0, 5'd9, 1, 1, 0, 3'b100, 3,
          32'h80FF_FF7F, 0);
    chk("lbu_data", l_wbdata, 32'h0000_0080);

    do_op(32'h102, 0, 5'd10, 1, 1, 0, 3'b001, 2,
          32'h8001_1234, 0);
    chk("lh_data", l_wbdata, 32'hFFFF_8001);
    do_op(32'h100, 0, 5'd11, 1, 1, 0, 3'b101, 1,
          32'h1234_F00D, 0);
    chk("lhu_data", l_wbdata, 32'h0000_F00D);
    do_op(32'h200, 0, 5'd12, 1, 1, 0, 3'b010, 1,
          32'hDEAD_BEEF, 0);

    do_op(32'h202, 32'h1234_ABCD, 5'd13, 1, 0, 1,
          3'b001, 2, 32'hFFFF_FFFF, 0);
    chk("sh_wdata", l_wdata, 32'hABCD_ABCD);
    chk("sh_be", 32'(l_be), 32'hC);
    chk("sh_we", 32'(l_we), 32'd1);
    chk("sh_rw", 32'(l_rw), 32'd0);
    do_op(32'h301, 32'h0000_0055, 5'd14, 1, 0, 1,
          3'b000, 2, 0, 0);
    chk("sb_be", 32'(l_be), 32'h2);

    do_op(32'h304, 32'hCAFE_F00D, 5'd15, 0, 0, 1,
          3'b010, 2, 0, 1);
    chk("b2b_rd", 32'(l_rd), 32'd7);
    chk("b2b_data", l_wbdata, 32'h00C0_FFEE);

    r0 = n_req; m0 = n_mis;
    do_op(32'h101, 0, 5'd16, 1, 1, 0, 3'b010, 1, 0, 0);
    chk("lw_mis_pulse", 32'(n_mis - m0), 32'd1);
    chk("lw_mis_no_req", 32'(n_req - r0), 32'd0);
    chk("lw_mis_rw", 32'(l_rw), 32'd0);
    do_op(32'h103, 0, 5'd17, 1, 1, 0, 3'b001, 1, 0, 0);
    do_op(32'h302, 32'h1, 5'd18, 0, 0, 1, 3'b010, 1, 0, 0);
    do_op(32'h0, 0, 5'd19, 1, 1, 0, 3'b011, 1, 0, 0);
    do_op(32'h0, 0, 5'd20, 1, 1, 0, 3'b110, 1, 0, 0);
    chk("bad_f3_no_req", 32'(n_req - r0), 32'd0);

    do_op(32'h10, 32'h9999_9999, 5'd21, 1, 1, 1, 3'b010, 1,
          32'h1122_3344, 0);
    chk("rdwr_we", 32'(l_we), 32'd0);
    chk("rdwr_data", l_wbdata, 32'h1122_3344);

    s0 = n_stall; b0 = n_berr;
    do_op(32'h400, 0, 5'd22, 1, 1, 0, 3'b010, 0,
          32'h5A5A_5A5A, 0);
`ifdef MEM_ACK_TIMEOUT_EN
    chk("to_berr", 32'(n_berr - b0), 32'd1);
    chk("to_stall", 32'(n_stall - s0), 32'(TO));
`else
    chk("noto_berr", 32'(n_berr - b0), 32'd0);
    chk("noto_stall", 32'(n_stall - s0), 32'(TO + 5));
`endif

    ex_valid = 1; ex_alu_result = 32'h80;
    ex_rd = 5'd23; ex_reg_write = 1;
    ex_mem_read = 1; ex_mem_write = 0;
    ex_funct3 = 3'b010;
    tick();
    ex_valid = 0;
    e_stall = 1; e_req = 1; e_we = 0;
    e_addr = 32'h80; e_be = 4'hF;
    tick();
    #2;
    rst = 1;
    clr_exp();
    #1;
    chk("rst_req_now", 32'(dmem_req), 32'd0);
    chk("rst_stall_now", 32'(mem_stall), 32'd0);
    w0 = n_wbv;
    dmem_ack = 1; dmem_rdata = 32'h1234_5678;
    repeat (2) tick();
    dmem_ack = 0; dmem_rdata = 0;
    rst = 0;
    do_op(32'h77, 0, 5'd3, 1, 0, 0, 3'b000, 1, 0, 0);
    chk("rst_one_wb", 32'(n_wbv - w0), 32'd1);
    chk("rst_after_data", l_wbdata, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16, the maximum number of WAIT cycles without dmem_ack before a bus error.
REQ-002 SHALL use a single clock; reset is asynchronous and active-high.
REQ-003 SHALL have port: clk  in  1  rising-edge clock.
REQ-004 SHALL have port: rst  in  1  async active-high reset.
REQ-005 SHALL have port: ex_valid  in  1  EX result present this cycle.
REQ-006 SHALL have port: ex_alu_result  in  32  EX Result (address for memory ops, writeback value otherwise).
REQ-007 SHALL have port: ex_store_data  in  32  rs2 value for stores.
REQ-008 SHALL have ports: ex_rd  in  5; ex_reg_write  in  1; ex_mem_read  in  1; ex_mem_write  in  1; ex_funct3  in  3.
REQ-009 SHALL have port: mem_stall  out  1  upstream hold request.
REQ-010 SHALL have ports: dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32 (word-aligned, [1:0]=0); dmem_wdata  out  32; dmem_be  out  4.
REQ-011 SHALL have ports: dmem_ack  in  1; dmem_rdata  in  32.
REQ-012 SHALL have ports: wb_valid  out  1; wb_rd  out  5; wb_reg_write  out  1; wb_data  out  32.
REQ-013 SHALL have ports: misaligned  out  1 (one-cycle pulse); bus_err  out  1 (one-cycle pulse).

Function
REQ-014 SHALL implement FSM IDLE/WAIT; ex_valid is sampled only in IDLE and ignored in WAIT.
REQ-015 Non-memory op (mem_read=mem_write=0) accepted at edge N SHALL drive wb_valid=1, wb_data=ex_alu_result, wb_rd, wb_reg_write for exactly one cycle after edge N; the FSM stays in IDLE.
REQ-016 An aligned memory op accepted at edge N SHALL enter WAIT and assert dmem_req from edge N onward.
REQ-017 In WAIT, dmem_req/we/addr/wdata/be SHALL hold stable until dmem_ack is sampled high.
REQ-018 mem_stall SHALL equal (state==WAIT), combinationally.
REQ-019 When dmem_ack is sampled high in WAIT, the block SHALL drop dmem_req at the same edge, return to IDLE, and pulse wb_valid for one cycle.
REQ-020 For loads, wb_reg_write SHALL follow ex_reg_write; for stores, wb_reg_write SHALL be 0.
REQ-021 Alignment: byte ops are always aligned; halfword ops require addr[0]=0; word ops require addr[1:0]=0.
REQ-022 Store lanes: SB SHALL replicate the byte to 4 lanes with be=1<<addr[1:0]; SH SHALL replicate the halfword with be=0011 (addr[1]=0) or 1100; SW SHALL use be=1111.
REQ-023 Loads SHALL select the lane by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through; for loads dmem_be SHALL equal the access mask.
REQ-024 A misaligned access, or funct3 in {011,110,111} with a memory op, SHALL issue no dmem_req, pulse misaligned, and pulse wb_valid with wb_reg_write=0.
REQ-025 mem_read=mem_write=1 SHALL be treated as a load.
REQ-026 A back-to-back op presented at the edge that returns the FSM to IDLE SHALL be accepted at the following edge (one idle bubble minimum between memory ops).

Reset
REQ-027 rst SHALL immediately force IDLE and set every output and internal register to 0, including dmem_req mid-WAIT; the aborted op produces no wb_valid.
REQ-028 The first edge after rst deasserts SHALL accept ex_valid normally.

Configuration
REQ-029 With MEM_ACK_TIMEOUT_EN defined, a WAIT-cycle counter SHALL reach ACK_TIMEOUT; the block then drops dmem_req, pulses bus_err, pulses wb_valid with wb_reg_write=0, and returns to IDLE. The counter clears on entry to WAIT.
REQ-030 Without MEM_ACK_TIMEOUT_EN, the counter SHALL be absent, WAIT SHALL last indefinitely, and bus_err SHALL be tied to 0.

Verification
REQ-031 ADD result 15, rd=5, reg_write=1 -> wb_valid one cycle later with wb_data=15, wb_rd=5; dmem_req stays 0.
REQ-032 LB addr=0x103, rdata=0x80FF_FF7F, ack after 3 cycles -> dmem_addr=0x100; mem_stall high 3 cycles; wb_data=0xFFFF_FF80; LBU gives 0x80.
REQ-033 SH addr=0x202, data=0x1234_ABCD -> wdata=0xABCD_ABCD, be=1100, we=1; wb_reg_write=0.
REQ-034 LW addr=0x101 -> misaligned pulse, no dmem_req, wb_valid with wb_reg_write=0.
REQ-035 rst asserted mid-WAIT -> dmem_req=0 immediately; no wb_valid afterwards.
REQ-036 MEM_ACK_TIMEOUT_EN defined, ACK_TIMEOUT=16, ack never arrives -> bus_err pulse after 16 WAIT cycles, FSM returns to IDLE.
